// File: rtl/dram_cmd_scheduler.sv
// In-order DRAM command scheduler: buffers parsed ops in a FIFO and issues one
// closed-page ACT -> RD/WR -> PRE sequence per request under clk-cycle timing.
module dram_cmd_scheduler #(
  parameter int ADDRESS_WIDTH = 33,
  parameter int DEPTH         = 16,
  parameter int TRCD          = 24,
  parameter int TCL           = 24,
  parameter int TCWL          = 20,
  parameter int TBURST        = 4,
  parameter int TRAS          = 52,
  parameter int TRP           = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [1:0]                 in_opcode,
  input  logic [ADDRESS_WIDTH-1:0]   in_address,
  output logic                       in_ready,
  output logic                       cmd_valid,
  output logic [1:0]                 cmd,
  output logic [1:0]                 cmd_bg,
  output logic [1:0]                 cmd_bank,
  output logic [14:0]                cmd_row,
  output logic [10:0]                cmd_col,
  output logic                       req_done,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       q_full,
  output logic                       q_empty,
  output logic [2:0]                 dbg_state
);
  localparam int PW = $clog2(DEPTH);
  // Entry = {is_write, address[ADDRESS_WIDTH-1:3]}; the byte offset is never used.
  localparam int EW = ADDRESS_WIDTH - 2;

  localparam int RD_PRE = (TRAS > TRCD + TCL + TBURST)  ? TRAS : TRCD + TCL + TBURST;
  localparam int WR_PRE = (TRAS > TRCD + TCWL + TBURST) ? TRAS : TRCD + TCWL + TBURST;

  function automatic logic [7:0] sat8(input int v);
    if (v > 255)    return 8'hFF;
    else if (v < 0) return 8'h00;
    else            return 8'(v);
  endfunction

  // Counters are loaded with (wait cycles - 1) so the last wait cycle sees zero.
  localparam logic [7:0] LD_RCD    = sat8(TRCD - 2);
  localparam logic [7:0] LD_PRE_RD = sat8(RD_PRE - TRCD - 2);
  localparam logic [7:0] LD_PRE_WR = sat8(WR_PRE - TRCD - 2);
  localparam logic [7:0] LD_RP     = sat8(TRP - 2);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_PRE, S_PRE, S_WAIT_RP
  } state_t;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  state_t        r_state, w_state_nxt;
  logic [7:0]    r_wait, w_wait_nxt;
  logic          w_push, w_pop, w_head_wr;
  logic [EW-1:0] w_head;

  // Handshake: an op transfers on a posedge where in_valid && in_ready; NOPs are
  // consumed without being stored; the requester must hold its op until in_ready.
  assign q_count   = r_count;
  assign q_full    = (r_count == CNT_FULL);
  assign q_empty   = (r_count == '0);
  assign in_ready  = !q_full;
  assign w_push    = in_valid && in_ready && (in_opcode != 2'd3);
  assign w_pop     = req_done;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_wr = w_head[EW-1];
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {(in_opcode == 2'd1), in_address[ADDRESS_WIDTH-1:3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Head address bits relative to the entry: col_lo [2:0], bg [4:3], bank [6:5],
  // col_hi [14:7], row [29:15].
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = (r_wait != 8'd0) ? r_wait - 8'd1 : 8'd0;
    cmd_valid   = 1'b0;
    cmd         = 2'd0;
    cmd_bg      = 2'd0;
    cmd_bank    = 2'd0;
    cmd_row     = 15'd0;
    cmd_col     = 11'd0;
    req_done    = 1'b0;
    case (r_state)
      S_IDLE: if (!q_empty) w_state_nxt = S_ACT;
      S_ACT: begin
        cmd_valid   = 1'b1;
        cmd         = 2'd0;
        cmd_bg      = w_head[4:3];
        cmd_bank    = w_head[6:5];
        cmd_row     = w_head[29:15];
        w_state_nxt = S_WAIT_RCD;
        w_wait_nxt  = LD_RCD;
      end
      S_WAIT_RCD: if (r_wait == 8'd0) w_state_nxt = S_CAS;
      S_CAS: begin
        cmd_valid   = 1'b1;
        cmd         = w_head_wr ? 2'd2 : 2'd1;
        cmd_bg      = w_head[4:3];
        cmd_bank    = w_head[6:5];
        cmd_col     = {w_head[14:7], w_head[2:0]};
        w_state_nxt = S_WAIT_PRE;
        w_wait_nxt  = w_head_wr ? LD_PRE_WR : LD_PRE_RD;
      end
      S_WAIT_PRE: if (r_wait == 8'd0) w_state_nxt = S_PRE;
      S_PRE: begin
        cmd_valid   = 1'b1;
        cmd         = 2'd3;
        cmd_bg      = w_head[4:3];
        cmd_bank    = w_head[6:5];
        req_done    = 1'b1;
        w_state_nxt = S_WAIT_RP;
        w_wait_nxt  = LD_RP;
      end
      S_WAIT_RP: if (r_wait == 8'd0) w_state_nxt = q_empty ? S_IDLE : S_ACT;
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: timestamped reference model feeds an expected
// command queue; a negedge monitor compares every command and the queue flags.
module tb_dram_cmd_scheduler;
  localparam int AW = 33, DEPTH = 16;
  localparam int TRCD = 24, TCL = 24, TCWL = 20, TBURST = 4, TRAS = 52, TRP = 24;
  localparam int W = 65;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_opcode = 2'd0;
  logic [AW-1:0] in_address = '0;
  logic          in_ready, cmd_valid, req_done, q_full, q_empty;
  logic [1:0]    cmd, cmd_bg, cmd_bank;
  logic [14:0]   cmd_row;
  logic [10:0]   cmd_col;
  logic [4:0]    q_count;
  logic [2:0]    dbg_state;

  dram_cmd_scheduler dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_address(in_address), .in_ready(in_ready), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .req_done(req_done), .q_count(q_count), .q_full(q_full), .q_empty(q_empty),
    .dbg_state(dbg_state)
  );

  // Clock / reset: cyc is the index of the last posedge; "cycle c" follows edge c.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state.
  logic [W-1:0] exp_q[$];
  int push_e[$];
  int pre_c[$];
  int act_log[$], cas_log[$], pre_log[$];
  int next_ok = -1000;
  int last_push = 0;
  int n_checks = 0, n_fail = 0;

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s @cycle %0d", name, cyc);
  endfunction

  function automatic int model_count(input int c);
    int n = 0;
    foreach (push_e[i]) if (push_e[i] <= c) n++;
    foreach (pre_c[i]) if (pre_c[i] + 1 <= c) n--;
    return n;
  endfunction

  function automatic logic [W-1:0] ev(input int c, input logic [1:0] k, input logic [1:0] bg,
                                      input logic [1:0] bank, input logic [14:0] row,
                                      input logic [10:0] col, input logic done);
    return {32'(c), k, bg, bank, row, col, done};
  endfunction

  // Reference model: a request accepted at edge n activates at the later of n+1
  // and the previous PRE + TRP; PRE waits for both TRAS and the data burst.
  function automatic void model_accept(input int n, input logic [1:0] op, input logic [AW-1:0] a);
    int t, lat, p;
    logic [10:0] col;
    col = {a[17:10], a[5:3]};
    t   = (n + 1 > next_ok) ? n + 1 : next_ok;
    lat = (op == 2'd1) ? TCWL : TCL;
    p   = t + ((TRAS > TRCD + lat + TBURST) ? TRAS : TRCD + lat + TBURST);
    next_ok = p + TRP;
    push_e.push_back(n);
    pre_c.push_back(p);
    exp_q.push_back(ev(t, 2'd0, a[7:6], a[9:8], a[32:18], 11'd0, 1'b0));
    exp_q.push_back(ev(t + TRCD, (op == 2'd1) ? 2'd2 : 2'd1, a[7:6], a[9:8], 15'd0, col, 1'b0));
    exp_q.push_back(ev(p, 2'd3, a[7:6], a[9:8], 15'd0, 11'd0, 1'b1));
  endfunction

  // Driver tasks.
  task automatic drive_op(input logic [1:0] op, input logic [AW-1:0] a);
    int tries = 0;
    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_address = a;
    while (op != 2'd3) begin
      if (model_count(cyc) < DEPTH) begin
        model_accept(cyc + 1, op, a);
        last_push = cyc + 1;
        break;
      end
      tries++;
      if (tries > 3000) begin flag_fail("accept_timeout"); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 6000) begin @(negedge clk); n++; end
    if (exp_q.size() > 0) flag_fail("drain_timeout");
    repeat (TRP + 2) @(negedge clk);
  endtask

  task automatic clear_logs();
    act_log.delete(); cas_log.delete(); pre_log.delete();
  endtask

  function automatic int log_at(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  // Monitor.
  always @(negedge clk) begin
    int mc;
    logic [W-1:0] got, e;
    mc = model_count(cyc);
    check("q_count", q_count, mc);
    check("q_full", q_full, mc == DEPTH);
    check("q_empty", q_empty, mc == 0);
    check("in_ready", in_ready, mc < DEPTH);
    while (exp_q.size() > 0 && int'(exp_q[0][64:33]) < cyc) begin
      e = exp_q.pop_front();
      $display("FAIL missed_cmd @cycle %0d: expected 0x%0h never seen", cyc, e);
      n_checks++; n_fail++;
    end
    if (cmd_valid || req_done) begin
      check("cmd_valid", cmd_valid, 1);
      got = {32'(cyc), cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, req_done};
      if (cmd == 2'd0) act_log.push_back(cyc);
      else if (cmd == 2'd3) pre_log.push_back(cyc);
      else cas_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_cmd @cycle %0d: got 0x%0h", cyc, got);
      end else begin
        e = exp_q.pop_front();
        check("cmd_event", got, e);
      end
    end else begin
      check("idle_fields", {cmd, cmd_bg, cmd_bank, cmd_row, cmd_col}, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout @cycle %0d", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    int p0, p1;
    logic [AW-1:0] a;
    logic [1:0] op;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_q_empty", q_empty, 1);
    check("rst_q_count", q_count, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_state", dbg_state, 0);
    #2 rst_n = 1'b1;

    // 1: single READ
    clear_logs();
    drive_op(2'd0, 33'h0_0000_0FC8);
    p0 = last_push;
    wait_drain();
    check("t1_act", log_at(act_log, 0), p0 + 1);
    check("t1_rd", log_at(cas_log, 0), p0 + 25);
    check("t1_pre", log_at(pre_log, 0), p0 + 53);

    // 2: WRITE, TRAS-bound
    clear_logs();
    drive_op(2'd1, 33'h0_0000_0FC8);
    p0 = last_push;
    wait_drain();
    check("t2_wr", log_at(cas_log, 0), p0 + 25);
    check("t2_pre", log_at(pre_log, 0), p0 + 53);

    // 3: back-to-back READs
    clear_logs();
    drive_op(2'd0, 33'h1_2345_6789);
    p0 = last_push;
    drive_op(2'd2, 33'h0_ABCD_EF01);
    wait_drain();
    check("t3_act2", log_at(act_log, 1), p0 + 77);
    check("t3_rp", log_at(act_log, 1) - log_at(pre_log, 0), TRP);

    // 4: fill past capacity
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      a = {1'($urandom), $urandom};
      drive_op(2'($urandom_range(0, 2)), a);
    end
    p0 = last_push;
    @(negedge clk);
    check("t4_full", q_full, 1);
    check("t4_not_ready", in_ready, 0);
    a = {1'($urandom), $urandom};
    drive_op(2'($urandom_range(0, 2)), a);
    p1 = last_push;
    check("t4_17th_accept", p1, log_at(pre_log, 0) + 2);
    wait_drain();
    check("t4_done_count", pre_log.size(), 17);

    // 5: NOP dropped
    clear_logs();
    drive_op(2'd3, 33'h0_0000_0FC8);
    repeat (10) @(negedge clk);
    check("t5_count", q_count, 0);
    check("t5_no_cmd", act_log.size(), 0);

    // 6: reset mid-request
    clear_logs();
    drive_op(2'd0, 33'h0_0000_0FC8);
    p0 = last_push;
    while (cyc < p0 + 30) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete(); push_e.delete(); pre_c.delete(); next_ok = -1000;
    #1;
    check("t6_cmd_valid", cmd_valid, 0);
    check("t6_fields", {cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, req_done}, 0);
    check("t6_q_count", q_count, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_q_empty", q_empty, 1);
    check("t6_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
    repeat (100) @(negedge clk);
    check("t6_no_pre", pre_log.size(), 0);
    check("t6_empty_after", q_empty, 1);

    // Random mix with gaps and NOPs
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = {1'($urandom), $urandom};
      drive_op(op, a);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
